// File: rtl/alu_pkg.sv
// Shared opcode constants and arbiter FSM state type for the ALU and its
// two-requester arbiter.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_EQ  = 4'd8;
  localparam logic [3:0] OP_LT  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU. Shifts use the low log2(DATA_WIDTH) bits of src_b, and
// LT is a signed compare. Any opcode not listed yields zero.
module alu #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  input  logic [OPCODE_LENGTH-1:0] op,
  output logic [DATA_WIDTH-1:0]    result
);
  import alu_pkg::*;

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = src_b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      OPCODE_LENGTH'(OP_AND): result = src_a & src_b;
      OPCODE_LENGTH'(OP_OR):  result = src_a | src_b;
      OPCODE_LENGTH'(OP_ADD): result = src_a + src_b;
      OPCODE_LENGTH'(OP_SUB): result = src_a - src_b;
      OPCODE_LENGTH'(OP_SLL): result = src_a << shamt;
      OPCODE_LENGTH'(OP_SRL): result = src_a >> shamt;
      OPCODE_LENGTH'(OP_XOR): result = src_a ^ src_b;
      OPCODE_LENGTH'(OP_SRA): result = DATA_WIDTH'($signed(src_a) >>> shamt);
      OPCODE_LENGTH'(OP_EQ):  result = DATA_WIDTH'(src_a == src_b);
      OPCODE_LENGTH'(OP_LT):  result = DATA_WIDTH'($signed(src_a) < $signed(src_b));
      default:                result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters (IDLE/EXEC/RESP).
// Define ALU_ARB_PERF_CNT_EN to build the saturating per-requester grant counters.
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [2*DATA_WIDTH-1:0]    req_src_a,
  input  logic [2*DATA_WIDTH-1:0]    req_src_b,
  input  logic [2*OPCODE_LENGTH-1:0] req_op,
  output logic [1:0]                 rsp_valid,
  input  logic [1:0]                 rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_result,
  output logic [31:0]                grant_cnt0,
  output logic [31:0]                grant_cnt1
);
  import alu_pkg::*;

  arb_state_t state_reg, state_next;
  logic                     id_reg;
  logic                     last_grant_reg;
  logic                     grant;
  logic                     accept;
  logic [1:0]               ready_raw;
  logic [DATA_WIDTH-1:0]    a_reg, b_reg, result_reg, alu_result;
  logic [OPCODE_LENGTH-1:0] op_reg;

  logic [DATA_WIDTH-1:0]    src_a_arr [2];
  logic [DATA_WIDTH-1:0]    src_b_arr [2];
  logic [OPCODE_LENGTH-1:0] op_arr    [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign src_a_arr[gi] = req_src_a[gi*DATA_WIDTH +: DATA_WIDTH];
    assign src_b_arr[gi] = req_src_b[gi*DATA_WIDTH +: DATA_WIDTH];
    assign op_arr[gi]    = req_op[gi*OPCODE_LENGTH +: OPCODE_LENGTH];
  end

  // Contention goes to the requester not served last; a lone request always wins.
  assign grant = (req_valid == 2'b11) ? ~last_grant_reg : req_valid[1];

  always_comb begin
    state_next = state_reg;
    ready_raw  = '0;
    rsp_valid  = '0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          ready_raw[grant] = 1'b1;
          accept           = 1'b1;
          state_next       = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp_valid[id_reg] = 1'b1;
        if (rsp_ready[id_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Keep ready low while reset is held even if requesters are already valid.
  assign req_ready  = reset ? 2'b00 : ready_raw;
  assign rsp_result = result_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      id_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= '0;
      result_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        id_reg         <= grant;
        last_grant_reg <= grant;
        a_reg          <= src_a_arr[grant];
        b_reg          <= src_b_arr[grant];
        op_reg         <= op_arr[grant];
      end
      if (state_reg == EXEC) result_reg <= alu_result;
    end
  end

  alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_alu (
    .src_a (a_reg),
    .src_b (b_reg),
    .op    (op_reg),
    .result(alu_result)
  );

`ifdef ALU_ARB_PERF_CNT_EN
  logic [31:0] cnt0_reg, cnt1_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_reg <= '0;
      cnt1_reg <= '0;
    end else if (accept) begin
      if (!grant && cnt0_reg != 32'hFFFF_FFFF) cnt0_reg <= cnt0_reg + 32'd1;
      if (grant && cnt1_reg != 32'hFFFF_FFFF)  cnt1_reg <= cnt1_reg + 32'd1;
    end
  end

  assign grant_cnt0 = cnt0_reg;
  assign grant_cnt1 = cnt1_reg;
`else
  assign grant_cnt0 = 32'd0;
  assign grant_cnt1 = 32'd0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic, all compared every cycle against a transaction-level model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_src_a, req_src_b;
  logic [7:0]  req_op;
  logic [31:0] rsp_result, grant_cnt0, grant_cnt1;

  alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_a(req_src_a), .req_src_b(req_src_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Model: an operation is either absent or in flight, aged in cycles since accept.
  bit          m_busy;
  int          m_age;
  int          m_owner;
  int          m_last;
  logic [31:0] m_res;
  logic [31:0] m_cnt [2];

  logic [1:0]  s_ready, s_valid;
  logic [31:0] s_result;
  logic [1:0]  grants [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a + b;
      3: return a - b;
      4: return a << sh;
      5: return a >> sh;
      6: return a ^ b;
      7: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      8: return (a == b) ? 32'd1 : 32'd0;
      9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_owner = 0; m_last = 1; m_res = '0;
    m_cnt[0] = '0; m_cnt[1] = '0;
  endtask

  task automatic set_req(input int i, input int op, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]        = 1'b1;
    req_op[i*4 +: 4]    = 4'(op);
    req_src_a[i*32 +: 32] = a;
    req_src_b[i*32 +: 32] = b;
  endtask

  // One clock: entered just after a negedge with inputs driven; compares, advances model.
  task automatic cycle();
    logic [1:0]  er, ev;
    logic [31:0] ec0, ec1;
    int          g;
    bit          took;
    #1;
    s_ready = req_ready; s_valid = rsp_valid; s_result = rsp_result;
    er = 2'b00; ev = 2'b00; g = 0; took = 1'b0;
    if (req_valid == 2'b11) g = 1 - m_last;
    else g = req_valid[1] ? 1 : 0;
    if (!reset) begin
      if (!m_busy && req_valid != 2'b00) er[g] = 1'b1;
      if (m_busy && m_age >= 2) ev[m_owner] = 1'b1;
    end
`ifdef ALU_ARB_PERF_CNT_EN
    ec0 = reset ? 32'd0 : m_cnt[0];
    ec1 = reset ? 32'd0 : m_cnt[1];
`else
    ec0 = 32'd0;
    ec1 = 32'd0;
`endif
    chk("req_ready", {62'd0, req_ready}, {62'd0, er});
    chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, ev});
    if (reset) chk("rsp_result_reset", {32'd0, rsp_result}, 64'd0);
    else if (ev != 2'b00) chk("rsp_result", {32'd0, rsp_result}, {32'd0, m_res});
    chk("grant_cnt0", {32'd0, grant_cnt0}, {32'd0, ec0});
    chk("grant_cnt1", {32'd0, grant_cnt1}, {32'd0, ec1});
    if (reset) model_reset();
    else if (!m_busy) begin
      if (req_valid != 2'b00) begin
        m_busy = 1'b1; m_age = 1; m_owner = g; m_last = g; took = 1'b1;
        m_res = ref_alu(int'(req_op[g*4 +: 4]), req_src_a[g*32 +: 32], req_src_b[g*32 +: 32]);
        if (m_cnt[g] != 32'hFFFF_FFFF) m_cnt[g] = m_cnt[g] + 32'd1;
      end
    end else if (m_age == 1) m_age = 2;
    else if (rsp_ready[m_owner]) m_busy = 1'b0;
    @(negedge clk);
    if (took) req_valid[g] = 1'b0;
  endtask

  task automatic do_op(input int i, input int op, input logic [31:0] a, input logic [31:0] b);
    set_req(i, op, a, b);
    cycle(); cycle(); cycle();
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    req_src_a = '0; req_src_b = '0; req_op = '0;
    model_reset();
    @(negedge clk);
    cycle(); cycle();
    reset = 1'b0;

    // Lone requester 0: ADD 5+7 -> 12 two cycles after the accept cycle.
    rsp_ready = 2'b11;
    set_req(0, 2, 32'd5, 32'd7);
    cycle(); chk("add_accept_ready", {62'd0, s_ready}, 64'd1);
    cycle(); chk("add_exec_no_valid", {62'd0, s_valid}, 64'd0);
    cycle(); chk("add_rsp_valid", {62'd0, s_valid}, 64'd1);
    chk("add_result_12", {32'd0, s_result}, 64'd12);

    // Contention from reset: req0 SUB 10-3 first, then req1 LT -1<1.
    reset = 1'b1; cycle(); reset = 1'b0;
    set_req(0, 3, 32'd10, 32'd3);
    set_req(1, 9, 32'hFFFF_FFFF, 32'd1);
    cycle(); chk("contend_first_grant", {62'd0, s_ready}, 64'd1);
    cycle(); cycle(); chk("sub_result_7", {32'd0, s_result}, 64'd7);
    cycle(); chk("contend_second_grant", {62'd0, s_ready}, 64'd2);
    cycle(); cycle(); chk("lt_result_1", {32'd0, s_result}, 64'd1);
    chk("lt_rsp_valid", {62'd0, s_valid}, 64'd2);

    // Both valid continuously: grants alternate.
    for (int k = 0; k < 4; k++) begin
      if (!req_valid[0]) set_req(0, 2, 32'(k), 32'd1);
      if (!req_valid[1]) set_req(1, 6, 32'(k), 32'd3);
      cycle(); grants[k] = s_ready;
      cycle(); cycle();
    end
    chk("alt_grant0", {62'd0, grants[0]}, 64'd1);
    chk("alt_grant1", {62'd0, grants[1]}, 64'd2);
    chk("alt_grant2", {62'd0, grants[2]}, 64'd1);
    chk("alt_grant3", {62'd0, grants[3]}, 64'd2);
    req_valid = 2'b00;

    // Response back-pressure; non-owner rsp_ready must be ignored.
    rsp_ready = 2'b00;
    set_req(0, 2, 32'd1, 32'd2);
    set_req(1, 2, 32'd2, 32'd3);
    cycle(); chk("bp_accept", {62'd0, s_ready}, 64'd1);
    rsp_ready = 2'b10;
    cycle();
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("bp_hold_valid", {62'd0, s_valid}, 64'd1);
      chk("bp_hold_result", {32'd0, s_result}, 64'd3);
      chk("bp_no_accept", {62'd0, s_ready}, 64'd0);
    end
    rsp_ready = 2'b01;
    cycle(); chk("bp_release_valid", {62'd0, s_valid}, 64'd1);
    cycle(); chk("bp_resume_accept", {62'd0, s_ready}, 64'd2);
    rsp_ready = 2'b11;
    cycle(); cycle(); chk("bp_second_result", {32'd0, s_result}, 64'd5);

    // Reset during EXEC aborts the op; next contention favours requester 0.
    set_req(0, 2, 32'd100, 32'd23);
    cycle();
    reset = 1'b1;
    set_req(0, 2, 32'd4, 32'd4);
    set_req(1, 2, 32'd1, 32'd1);
    cycle();
    chk("rst_exec_ready", {62'd0, s_ready}, 64'd0);
    chk("rst_exec_valid", {62'd0, s_valid}, 64'd0);
    chk("rst_exec_result", {32'd0, s_result}, 64'd0);
    reset = 1'b0;
    cycle(); chk("rst_next_grant", {62'd0, s_ready}, 64'd1);
    for (int k = 0; k < 8; k++) cycle();

    // Counters and unsupported opcode.
    req_valid = 2'b00;
    reset = 1'b1; cycle(); reset = 1'b0;
    do_op(0, 2, 32'd1, 32'd1);
    do_op(1, 15, 32'hDEAD_BEEF, 32'd77);
    chk("op15_result_0", {32'd0, s_result}, 64'd0);
    do_op(0, 4, 32'd1, 32'd4);
    chk("sll_result_16", {32'd0, s_result}, 64'd16);
    do_op(1, 7, 32'h8000_0000, 32'd4);
    chk("sra_result", {32'd0, s_result}, 64'hF800_0000);
    do_op(0, 8, 32'd9, 32'd9);
    cycle();
`ifdef ALU_ARB_PERF_CNT_EN
    chk("cnt0_is_3", {32'd0, grant_cnt0}, 64'd3);
    chk("cnt1_is_2", {32'd0, grant_cnt1}, 64'd2);
`else
    chk("cnt0_tied_0", {32'd0, grant_cnt0}, 64'd0);
    chk("cnt1_tied_0", {32'd0, grant_cnt1}, 64'd0);
`endif

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom));
      end
      rsp_ready = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and result width.
REQ-002 Parameter OPCODE_LENGTH, default 4: ALU operation code width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-006 req_ready  output  2  per-requester request accept; one-hot or zero.
REQ-007 req_src_a  input  2*DATA_WIDTH  operand A; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_src_b  input  2*DATA_WIDTH  operand B, same packing.
REQ-009 req_op  input  2*OPCODE_LENGTH  ALU operation code, same packing.
REQ-010 rsp_valid  output  2  per-requester result valid; one-hot or zero.
REQ-011 rsp_ready  input  2  per-requester result accept.
REQ-012 rsp_result  output  DATA_WIDTH  result, shared by both response channels; meaningful only while rsp_valid is nonzero.
REQ-013 grant_cnt0, grant_cnt1  output  32 each  accepted-request counters (see Configuration).

Function
REQ-014 The block SHALL share one ALU instance between two requesters, one operation in flight at a time.
REQ-015 FSM states SHALL be IDLE, EXEC and RESP.
REQ-016 IDLE: if any req_valid is high, the block SHALL assert req_ready for exactly the granted requester, register its operands, opcode and requester id, and go to EXEC on the next edge.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of history.
REQ-018 The last-grant pointer SHALL update only on an accepted request.
REQ-019 req_ready SHALL be zero in EXEC and RESP.
REQ-020 EXEC: the ALU SHALL compute from the registered operands; the result SHALL be registered and the FSM SHALL go to RESP after exactly one cycle.
REQ-021 RESP: rsp_valid[id] SHALL be high and rsp_result stable until rsp_ready[id] is high; on that edge the FSM SHALL return to IDLE.
REQ-022 rsp_ready of the non-owning requester SHALL be ignored.
REQ-023 Minimum latency SHALL be 2 cycles from the accept edge to rsp_valid; throughput SHALL be at most one operation per 3 cycles.
REQ-024 Unsupported opcodes SHALL return result 0.
REQ-025 Requests arriving while the block is busy SHALL be held off (ready low), never dropped; requesters SHALL hold valid and payload until ready.

Reset
REQ-026 Reset SHALL force IDLE and clear req_ready, rsp_valid, rsp_result, the operand registers and both counters to 0.
REQ-027 Reset SHALL set the last-grant pointer to 1, so requester 0 wins the first contention.
REQ-028 A reset during EXEC or RESP SHALL abort the operation with no response issued.

Configuration
REQ-029 With ALU_ARB_PERF_CNT_EN defined, grant_cnt0 and grant_cnt1 SHALL each increment on every accept for their requester and saturate at 32'hFFFF_FFFF.
REQ-030 Without ALU_ARB_PERF_CNT_EN, both counter outputs SHALL be tied to 0 and no counter flops SHALL be inferred.

Structure
REQ-031 A shared package alu_pkg SHALL hold the opcode constants (AND, OR, ADD, SUB, SLL, SRL, XOR, SRA, EQ, LT) and the FSM state enum.
REQ-032 The sole sub-module SHALL be the existing alu, instantiated once.

Verification
REQ-033 Only requester 0: ADD, 5 and 7 -> req_ready[0] on the accept cycle; rsp_valid[0] with result 12 two cycles later.
REQ-034 Both requesters valid from reset: req0 SUB 10,3; req1 SLT -1,1 -> req0 granted first (result 7), then req1 (result 1).
REQ-035 Both requesters valid continuously -> grants alternate 0,1,0,1.
REQ-036 rsp_ready held low for 4 cycles in RESP -> rsp_valid and result stable, no new accept; accept resumes one cycle after rsp_ready rises.
REQ-037 Reset asserted during EXEC -> outputs 0 immediately, no rsp_valid afterwards, and the next contention grants requester 0.
REQ-038 With ALU_ARB_PERF_CNT_EN: 3 ops from req0 and 2 from req1 -> grant_cnt0=3, grant_cnt1=2; opcode 4'b1111 -> result 0.
